// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, registered operand launch, programmable settle time,
// held response with valid/ready handshake, and a divide-by-zero guard.
// Optional feature macro: ALU_ARB_OVF_TRAP_EN adds a sticky overflow trap
// (ports ovf_trap, ovf_trap_id, trap_clr).
module alu_arbiter #(
    parameter int unsigned LAT = 1,
    parameter int unsigned CW  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_instr,
    input  logic [31:0] req0_gr1,
    input  logic [31:0] req0_gr2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_instr,
    input  logic [31:0] req1_gr1,
    input  logic [31:0] req1_gr2,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_gr1,
    output logic [31:0] alu_gr2,
    input  logic [31:0] alu_c,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_overflow,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_c,
    output logic        resp_zero,
    output logic        resp_neg,
    output logic        resp_ovf,
`ifdef ALU_ARB_OVF_TRAP_EN
    output logic        ovf_trap,
    output logic        ovf_trap_id,
    input  logic        trap_clr,
`endif
    output logic        resp_err
);

    localparam int unsigned DW      = 32;
    localparam int unsigned FW      = 6;
    localparam logic [FW-1:0] OP_SPECIAL = 6'b000000;
    localparam logic [FW-1:0] FN_DIV     = 6'b011010;
    localparam logic [FW-1:0] FN_DIVU    = 6'b011011;
    localparam logic [CW-1:0] CNT_START  = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            rr_last_q, rr_last_d;
    logic            owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   alu_instr_q, alu_instr_d;
    logic [DW-1:0]   alu_gr1_q, alu_gr1_d;
    logic [DW-1:0]   alu_gr2_q, alu_gr2_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_id_q, resp_id_d;
    logic [DW-1:0]   resp_c_q, resp_c_d;
    logic            resp_zero_q, resp_zero_d;
    logic            resp_neg_q, resp_neg_d;
    logic            resp_ovf_q, resp_ovf_d;
    logic            resp_err_q, resp_err_d;
`ifdef ALU_ARB_OVF_TRAP_EN
    logic            ovf_trap_q, ovf_trap_d;
    logic            ovf_trap_id_q, ovf_trap_id_d;
`endif

    logic            grant_vld;
    logic            grant_id;
    logic [DW-1:0]   win_instr;
    logic [DW-1:0]   win_gr1;
    logic [DW-1:0]   win_gr2;
    logic            win_div0;
    logic            capture;

    // Round-robin arbitration: a lone requester wins, a tie goes to the one that did not win last.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~rr_last_q;
        end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    // Winner's payload and divide-by-zero detection on that payload.
    always_comb begin
        win_instr = grant_id ? req1_instr : req0_instr;
        win_gr1   = grant_id ? req1_gr1   : req0_gr1;
        win_gr2   = grant_id ? req1_gr2   : req0_gr2;
        win_div0  = (win_instr[31:26] == OP_SPECIAL)
                 && ((win_instr[FW-1:0] == FN_DIV) || (win_instr[FW-1:0] == FN_DIVU))
                 && (win_gr2 == '0);
    end

    // Ready is only offered while idle, and only to the granted requester.
    assign req0_ready = (state_q == IDLE) && grant_vld && !grant_id;
    assign req1_ready = (state_q == IDLE) && grant_vld &&  grant_id;

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        alu_instr_d   = alu_instr_q;
        alu_gr1_d     = alu_gr1_q;
        alu_gr2_d     = alu_gr2_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_c_d      = resp_c_q;
        resp_zero_d   = resp_zero_q;
        resp_neg_d    = resp_neg_q;
        resp_ovf_d    = resp_ovf_q;
        resp_err_d    = resp_err_q;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    rr_last_d = grant_id;
                    owner_d   = grant_id;
                    if (win_div0) begin
                        // Blocked divide: answer directly, ALU inputs untouched.
                        resp_valid_d = 1'b1;
                        resp_id_d    = grant_id;
                        resp_c_d     = '0;
                        resp_zero_d  = 1'b0;
                        resp_neg_d   = 1'b0;
                        resp_ovf_d   = 1'b0;
                        resp_err_d   = 1'b1;
                        state_d      = RESP;
                    end else begin
                        alu_instr_d = win_instr;
                        alu_gr1_d   = win_gr1;
                        alu_gr2_d   = win_gr2;
                        cnt_d       = CNT_START;
                        state_d     = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    capture      = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_id_d    = owner_q;
                    resp_c_d     = alu_c;
                    resp_zero_d  = alu_zero;
                    resp_neg_d   = alu_neg;
                    resp_ovf_d   = alu_overflow;
                    resp_err_d   = 1'b0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

`ifdef ALU_ARB_OVF_TRAP_EN
    // Sticky trap: first overflow wins; a coinciding set beats a clear.
    always_comb begin
        ovf_trap_d    = ovf_trap_q;
        ovf_trap_id_d = ovf_trap_id_q;
        if (capture && alu_overflow && (!ovf_trap_q || trap_clr)) begin
            ovf_trap_d    = 1'b1;
            ovf_trap_id_d = owner_q;
        end else if (trap_clr) begin
            ovf_trap_d    = 1'b0;
        end
    end
`else
    // Capture strobe only feeds the optional trap.
    logic unused_capture;
    assign unused_capture = capture;
`endif

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_last_q     <= 1'b1;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            alu_instr_q   <= '0;
            alu_gr1_q     <= '0;
            alu_gr2_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_c_q      <= '0;
            resp_zero_q   <= 1'b0;
            resp_neg_q    <= 1'b0;
            resp_ovf_q    <= 1'b0;
            resp_err_q    <= 1'b0;
`ifdef ALU_ARB_OVF_TRAP_EN
            ovf_trap_q    <= 1'b0;
            ovf_trap_id_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            alu_instr_q   <= alu_instr_d;
            alu_gr1_q     <= alu_gr1_d;
            alu_gr2_q     <= alu_gr2_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_c_q      <= resp_c_d;
            resp_zero_q   <= resp_zero_d;
            resp_neg_q    <= resp_neg_d;
            resp_ovf_q    <= resp_ovf_d;
            resp_err_q    <= resp_err_d;
`ifdef ALU_ARB_OVF_TRAP_EN
            ovf_trap_q    <= ovf_trap_d;
            ovf_trap_id_q <= ovf_trap_id_d;
`endif
        end
    end

    assign alu_instr  = alu_instr_q;
    assign alu_gr1    = alu_gr1_q;
    assign alu_gr2    = alu_gr2_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_c     = resp_c_q;
    assign resp_zero  = resp_zero_q;
    assign resp_neg   = resp_neg_q;
    assign resp_ovf   = resp_ovf_q;
    assign resp_err   = resp_err_q;
`ifdef ALU_ARB_OVF_TRAP_EN
    assign ovf_trap    = ovf_trap_q;
    assign ovf_trap_id = ovf_trap_id_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized checks of alu_arbiter against a
// transaction-level reference model (one outstanding op, round-robin winner).
module tb_alu_arbiter;

    localparam int unsigned LAT = 1;
    localparam logic [31:0] I_ADD = 32'h0022_1820;
    localparam logic [31:0] I_SUB = 32'h0022_1822;
    localparam logic [31:0] I_DIV = 32'h0022_001A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (LAT=1)
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_instr, req0_gr1, req0_gr2, req1_instr, req1_gr1, req1_gr2;
    logic [31:0] alu_instr, alu_gr1, alu_gr2, alu_c;
    logic        alu_zero, alu_neg, alu_overflow;
    logic        resp_valid, resp_ready, resp_id, resp_zero, resp_neg, resp_ovf, resp_err;
    logic [31:0] resp_c;
    logic [32:0] alu_res;
`ifdef ALU_ARB_OVF_TRAP_EN
    logic        ovf_trap, ovf_trap_id, trap_clr;
`endif

    // Second DUT (LAT=3) for the reset-during-settle scenario
    logic        t3_rst_n, t3_v0, t3_r0, t3_r1, t3_rr;
    logic [31:0] t3_i0, t3_a0, t3_b0;
    logic [31:0] t3_alu_instr, t3_alu_gr1, t3_alu_gr2, t3_resp_c;
    logic        t3_resp_valid, t3_resp_id, t3_resp_zero, t3_resp_neg, t3_resp_ovf, t3_resp_err;
    logic [32:0] t3_alu_res;
`ifdef ALU_ARB_OVF_TRAP_EN
    logic        t3_trap, t3_trap_id;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural ALU used both as the environment and as the reference.
    function automatic logic [32:0] alu_eval(input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] c;
        logic        v;
        c = 32'd0;
        v = 1'b0;
        case (ins[5:0])
            6'h20: begin c = a + b; v = (a[31] == b[31]) && (c[31] != a[31]); end
            6'h22: begin c = a - b; v = (a[31] != b[31]) && (c[31] != a[31]); end
            6'h24: c = a & b;
            6'h25: c = a | b;
            6'h26: c = a ^ b;
            6'h1A: begin
                if (b == 32'd0) c = 32'hDEAD_BEEF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) c = a;
                else c = $signed(a) / $signed(b);
            end
            6'h1B: c = (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
            default: c = a ^ {b[15:0], b[31:16]};
        endcase
        return {v, c};
    endfunction

    assign alu_res      = alu_eval(alu_instr, alu_gr1, alu_gr2);
    assign alu_c        = alu_res[31:0];
    assign alu_overflow = alu_res[32];
    assign alu_zero     = (alu_res[31:0] == 32'd0);
    assign alu_neg      = alu_res[31];

    assign t3_alu_res   = alu_eval(t3_alu_instr, t3_alu_gr1, t3_alu_gr2);

    alu_arbiter #(.LAT(LAT), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
        .req0_gr1(req0_gr1), .req0_gr2(req0_gr2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
        .req1_gr1(req1_gr1), .req1_gr2(req1_gr2),
        .alu_instr(alu_instr), .alu_gr1(alu_gr1), .alu_gr2(alu_gr2),
        .alu_c(alu_c), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_overflow(alu_overflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_c(resp_c),
        .resp_zero(resp_zero), .resp_neg(resp_neg), .resp_ovf(resp_ovf),
`ifdef ALU_ARB_OVF_TRAP_EN
        .ovf_trap(ovf_trap), .ovf_trap_id(ovf_trap_id), .trap_clr(trap_clr),
`endif
        .resp_err(resp_err)
    );

    alu_arbiter #(.LAT(3), .CW(4)) dut3 (
        .clk(clk), .rst_n(t3_rst_n),
        .req0_valid(t3_v0), .req0_ready(t3_r0), .req0_instr(t3_i0),
        .req0_gr1(t3_a0), .req0_gr2(t3_b0),
        .req1_valid(1'b0), .req1_ready(t3_r1), .req1_instr(32'd0),
        .req1_gr1(32'd0), .req1_gr2(32'd0),
        .alu_instr(t3_alu_instr), .alu_gr1(t3_alu_gr1), .alu_gr2(t3_alu_gr2),
        .alu_c(t3_alu_res[31:0]), .alu_zero(t3_alu_res[31:0] == 32'd0),
        .alu_neg(t3_alu_res[31]), .alu_overflow(t3_alu_res[32]),
        .resp_valid(t3_resp_valid), .resp_ready(t3_rr), .resp_id(t3_resp_id), .resp_c(t3_resp_c),
        .resp_zero(t3_resp_zero), .resp_neg(t3_resp_neg), .resp_ovf(t3_resp_ovf),
`ifdef ALU_ARB_OVF_TRAP_EN
        .ovf_trap(t3_trap), .ovf_trap_id(t3_trap_id), .trap_clr(1'b0),
`endif
        .resp_err(t3_resp_err)
    );

    // Reference model state: idle/busy, last winner, last issued operands, held response.
    logic        m_busy, m_last, m_owner, m_rv, m_rid, m_rz, m_rn, m_ro, m_re;
    logic        p_z, p_n, p_o, p_e;
    logic [31:0] m_ai, m_a1, m_a2, m_rc, p_c;
    int          m_edges, m_lat;
`ifdef ALU_ARB_OVF_TRAP_EN
    logic        m_trap, m_trap_id;
`endif
    logic        seen0, seen1;
    logic        rv0, rv1;
    logic [31:0] ri0, ra0, rb0, ri1, ra1, rb1;
    logic        t2_q[$];
    int          n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_rv = 1'b0; m_rid = 1'b0;
        m_rz = 1'b0; m_rn = 1'b0; m_ro = 1'b0; m_re = 1'b0; m_rc = 32'd0;
        m_ai = 32'd0; m_a1 = 32'd0; m_a2 = 32'd0; m_edges = 0; m_lat = 0;
        p_c = 32'd0; p_z = 1'b0; p_n = 1'b0; p_o = 1'b0; p_e = 1'b0;
`ifdef ALU_ARB_OVF_TRAP_EN
        m_trap = 1'b0; m_trap_id = 1'b0;
`endif
    endtask

    task automatic check_outputs();
        check("resp_valid", resp_valid, m_rv);
        check("resp_id",    resp_id,    m_rid);
        check("resp_c",     resp_c,     m_rc);
        check("resp_zero",  resp_zero,  m_rz);
        check("resp_neg",   resp_neg,   m_rn);
        check("resp_ovf",   resp_ovf,   m_ro);
        check("resp_err",   resp_err,   m_re);
        check("alu_instr",  alu_instr,  m_ai);
        check("alu_gr1",    alu_gr1,    m_a1);
        check("alu_gr2",    alu_gr2,    m_a2);
`ifdef ALU_ARB_OVF_TRAP_EN
        check("ovf_trap",    ovf_trap,    m_trap);
        check("ovf_trap_id", ovf_trap_id, m_trap_id);
`endif
    endtask

    // One clock cycle: drive at negedge, check ready, advance model at posedge, check at negedge.
    task automatic step(input logic v0, input logic [31:0] i0, input logic [31:0] a0,
                        input logic [31:0] b0, input logic v1, input logic [31:0] i1,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic rr, input logic clr);
        logic        g_vld, g_id, dz, cap;
        logic [31:0] wi, wa, wb;
        logic [32:0] r;
        req0_valid = v0; req0_instr = i0; req0_gr1 = a0; req0_gr2 = b0;
        req1_valid = v1; req1_instr = i1; req1_gr1 = a1; req1_gr2 = b1;
        resp_ready = rr;
`ifdef ALU_ARB_OVF_TRAP_EN
        trap_clr = clr;
`endif
        #1;
        g_vld = !m_busy && (v0 || v1);
        g_id  = (v0 && v1) ? !m_last : !v0;
        seen0 = req0_ready;
        seen1 = req1_ready;
        check("req0_ready", req0_ready, g_vld && !g_id);
        check("req1_ready", req1_ready, g_vld && g_id);
        @(posedge clk);
        cap = 1'b0;
        if (g_vld) begin
            wi = g_id ? i1 : i0;
            wa = g_id ? a1 : a0;
            wb = g_id ? b1 : b0;
            m_last = g_id; m_owner = g_id; m_busy = 1'b1; m_edges = 1;
            dz = (wi[31:26] == 6'd0) && (wi[5:0] == 6'h1A || wi[5:0] == 6'h1B) && (wb == 32'd0);
            if (dz) begin
                m_lat = 1;
                p_c = 32'd0; p_z = 1'b0; p_n = 1'b0; p_o = 1'b0; p_e = 1'b1;
            end else begin
                m_lat = int'(LAT) + 1;
                m_ai = wi; m_a1 = wa; m_a2 = wb;
                r = alu_eval(wi, wa, wb);
                p_c = r[31:0]; p_z = (r[31:0] == 32'd0); p_n = r[31]; p_o = r[32]; p_e = 1'b0;
            end
            cap = (m_edges == m_lat);
        end else if (m_busy) begin
            if (m_rv) begin
                if (rr) begin m_busy = 1'b0; m_rv = 1'b0; end
            end else begin
                m_edges++;
                cap = (m_edges == m_lat);
            end
        end
        if (cap) begin
            m_rv = 1'b1; m_rid = m_owner; m_rc = p_c;
            m_rz = p_z; m_rn = p_n; m_ro = p_o; m_re = p_e;
        end
`ifdef ALU_ARB_OVF_TRAP_EN
        if (cap && p_o && (!m_trap || clr)) begin
            m_trap = 1'b1; m_trap_id = m_owner;
        end else if (clr) begin
            m_trap = 1'b0;
        end
`endif
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_step(input logic rr, input logic clr);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rr, clr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
`ifdef ALU_ARB_OVF_TRAP_EN
        trap_clr = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs();
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [5:0] f;
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0: f = 6'h20;
            1: f = 6'h22;
            2: f = 6'h24;
            3: f = 6'h25;
            4: f = 6'h26;
            5: f = 6'h1A;
            default: f = 6'h1B;
        endcase
        op = ($urandom_range(0, 3) == 0) ? 6'h23 : 6'h00;
        return {op, 20'($urandom), f};
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        t3_rst_n = 1'b0; t3_v0 = 1'b0; t3_i0 = 32'd0; t3_a0 = 32'd0; t3_b0 = 32'd0; t3_rr = 1'b0;
        req0_instr = 32'd0; req0_gr1 = 32'd0; req0_gr2 = 32'd0;
        req1_instr = 32'd0; req1_gr1 = 32'd0; req1_gr2 = 32'd0;
        seen0 = 1'b0; seen1 = 1'b0;
        model_reset();

        // Reset state
        do_reset();
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);

        // Single add from requester 0
        step(1'b1, I_ADD, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("t1_ready0", seen0, 1'b1);
        idle_step(1'b0, 1'b0);
        check("t1_valid", resp_valid, 1'b1);
        check("t1_c", resp_c, 32'd12);
        check("t1_id", resp_id, 1'b0);
        idle_step(1'b1, 1'b0);

        // Both requesters continuously valid after reset: grants alternate 0,1,0,1
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, I_ADD, 32'(k), 32'd1, 1'b1, I_SUB, 32'(k), 32'd1, 1'b1, 1'b0);
            if (seen0 || seen1) t2_q.push_back(seen1);
        end
        check("t2_count", 32'(t2_q.size()), 32'd4);
        for (int i = 0; i < t2_q.size(); i++) check("t2_order", t2_q[i], 32'(i % 2));
        repeat (3) idle_step(1'b1, 1'b0);

        // Response held under back-pressure while requester 1 waits
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, I_SUB, 32'd100, 32'd30, 1'b0, 1'b0);
        repeat (7) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, I_SUB, 32'd200, 32'd50, 1'b0, 1'b0);
        check("t3_c", resp_c, 32'd70);
        check("t3_id", resp_id, 1'b1);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, I_SUB, 32'd200, 32'd50, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, I_SUB, 32'd200, 32'd50, 1'b1, 1'b0);
        check("t3_accept1", seen1, 1'b1);
        repeat (3) idle_step(1'b1, 1'b0);

        // Divide by zero is answered directly, ALU inputs untouched
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, I_DIV, 32'd9, 32'd0, 1'b0, 1'b0);
        check("t4_valid", resp_valid, 1'b1);
        check("t4_err", resp_err, 1'b1);
        check("t4_c", resp_c, 32'd0);
        check("t4_alu_instr", alu_instr, I_SUB);
        idle_step(1'b1, 1'b0);

        // Signed overflow
        step(1'b1, I_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle_step(1'b0, 1'b0);
        check("t5_c", resp_c, 32'h8000_0000);
        check("t5_neg", resp_neg, 1'b1);
        check("t5_ovf", resp_ovf, 1'b1);
        idle_step(1'b1, 1'b0);
        repeat (3) idle_step(1'b0, 1'b0);
`ifdef ALU_ARB_OVF_TRAP_EN
        check("t5_trap", ovf_trap, 1'b1);
        check("t5_trap_id", ovf_trap_id, 1'b0);
        idle_step(1'b0, 1'b1);
        check("t5_trap_clr", ovf_trap, 1'b0);
`endif

        // Randomized traffic against the model
        rv0 = 1'b0; rv1 = 1'b0;
        ri0 = 32'd0; ra0 = 32'd0; rb0 = 32'd0; ri1 = 32'd0; ra1 = 32'd0; rb1 = 32'd0;
        seen0 = 1'b0; seen1 = 1'b0;
        repeat (1500) begin
            if (seen0 || !rv0) begin
                rv0 = ($urandom_range(0, 2) != 0);
                ri0 = rnd_instr(); ra0 = rnd_op(); rb0 = rnd_op();
            end else if ($urandom_range(0, 7) == 0) begin
                rv0 = 1'b0;
            end
            if (seen1 || !rv1) begin
                rv1 = ($urandom_range(0, 2) != 0);
                ri1 = rnd_instr(); ra1 = rnd_op(); rb1 = rnd_op();
            end else if ($urandom_range(0, 7) == 0) begin
                rv1 = 1'b0;
            end
            step(rv0, ri0, ra0, rb0, rv1, ri1, ra1, rb1,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        // LAT=3 instance: reset during settle drops the op; next op completes normally
        repeat (2) @(posedge clk);
        @(negedge clk);
        t3_rst_n = 1'b1;
        t3_v0 = 1'b1; t3_i0 = I_ADD; t3_a0 = 32'd10; t3_b0 = 32'd20;
        #1;
        check("t6_ready0", t3_r0, 1'b1);
        check("t6_ready1", t3_r1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        t3_v0 = 1'b0;
        check("t6_alu_gr1", t3_alu_gr1, 32'd10);
        @(posedge clk);
        @(negedge clk);
        check("t6_busy_valid", t3_resp_valid, 1'b0);
        t3_rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        t3_rst_n = 1'b1;
        check("t6_rst_alu", t3_alu_instr, 32'd0);
        check("t6_rst_valid", t3_resp_valid, 1'b0);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            check("t6_dropped", t3_resp_valid, 1'b0);
        end
        t3_v0 = 1'b1; t3_a0 = 32'd3; t3_b0 = 32'd4;
        #1;
        check("t6_ready0b", t3_r0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        t3_v0 = 1'b0;
        n = 1;
        while (!t3_resp_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("t6_latency", 32'(n), 32'd4);
        check("t6_c", t3_resp_c, 32'd7);
        check("t6_id", t3_resp_id, 1'b0);
        check("t6_err", t3_resp_err, 1'b0);
        check("t6_flags", {29'd0, t3_resp_zero, t3_resp_neg, t3_resp_ovf}, 32'd0);
`ifdef ALU_ARB_OVF_TRAP_EN
        check("t6_trap", {30'd0, t3_trap, t3_trap_id}, 32'd0);
`endif
        t3_rr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_release", t3_resp_valid, 1'b0);
        check("t6_hold_c", t3_resp_c, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
